// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the music-box song sequencer: FSM state codes,
// note-ROM entry layout and small sizing helpers.
package song_sequencer_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_PLAY  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    // ROM entry layout: {dur[3:0], note[5:0]}
    localparam int ENTRY_W    = 10;
    localparam int DUR_MSB    = 9;
    localparam int DUR_LSB    = 6;
    localparam int NOTE_MSB   = 5;
    localparam int NOTE_LSB   = 0;
    localparam int FULLNOTE_W = 11;

    localparam logic [3:0] END_MARKER = 4'd0;

    // Counter width for values 0..v-1, never below one bit.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Control and note-ROM bus between the song sequencer and its surroundings
// (player controls, shared note ROM, divider and LEDs).
interface song_sequencer_if
    import song_sequencer_pkg::*;
#(
    parameter int ADDR_W = 9
);

    logic                  pause;
    logic                  song_sel;
    logic [ADDR_W-1:0]     rom_addr;
    logic [ENTRY_W-1:0]    rom_data;
    logic [FULLNOTE_W-1:0] fullnote;
    logic                  note_start;
    logic                  song_done;
    logic                  playing;

    modport master (
        input  pause, song_sel, rom_data,
        output rom_addr, fullnote, note_start, song_done, playing
    );

    modport slave (
        output pause, song_sel, rom_data,
        input  rom_addr, fullnote, note_start, song_done, playing
    );

endinterface

// File: rtl/song_sequencer_tick_gen.sv
// Duration-tick prescaler: counts 0..DIV-1 while enabled and flags the
// terminal count with a one-cycle tick; a synchronous clear restarts it.
module song_sequencer_tick_gen
    import song_sequencer_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              CNT_W = clog2_min1(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/song_sequencer.sv
// Event-driven note sequencer: fetches {dur,note} entries from the shared
// note ROM, holds each note for its coded duration, then a silent gap.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int CLKF       = 100_000_000,
    parameter int TICK_HZ    = 64,
    parameter int UNIT_TICKS = 8,
    parameter int GAP_TICKS  = 2,
    parameter int ADDR_W     = 9,
    parameter int SONG1_BASE = 0,
    parameter int SONG2_BASE = 256,
    parameter int SONG_LEN   = 256,
    parameter int LOOP       = 1
) (
    input  logic             clk,
    input  logic             RESET,
    song_sequencer_if.master bus
);

    localparam int DIV   = CLKF / TICK_HZ;
    localparam int IDX_W = clog2_min1(SONG_LEN);
    localparam int DUR_W = clog2_min1(15 * UNIT_TICKS + 1);
    localparam int GAP_W = clog2_min1(GAP_TICKS + 1);

    logic [2:0]            state;
    logic [IDX_W-1:0]      idx;
    logic [DUR_W-1:0]      dur_ctr;
    logic [GAP_W-1:0]      gap_ctr;
    logic                  shadow;
    logic [ADDR_W-1:0]     rom_addr_q;
    logic [FULLNOTE_W-1:0] fullnote_q;
    logic                  note_start_q;
    logic                  song_done_q;

    logic                  tick;
    logic                  tick_en;
    logic                  tick_clr;
    logic                  song_change;
    logic                  note_end;
    logic                  gap_end;
    logic                  advance;
    logic                  at_last;
    logic                  end_marker;
    logic [ADDR_W-1:0]     base;

    assign song_change = (bus.song_sel != shadow);
    assign base        = shadow ? ADDR_W'(SONG2_BASE) : ADDR_W'(SONG1_BASE);
    assign at_last     = (idx == IDX_W'(SONG_LEN - 1));
    assign end_marker  = (bus.rom_data[DUR_MSB:DUR_LSB] == END_MARKER);

    // The prescaler only runs while a note or gap is actually sounding.
    assign tick_en  = !bus.pause && ((state == S_PLAY) || (state == S_GAP));
    assign tick_clr = (state == S_LOAD) || song_change;

    assign note_end = tick && (state == S_PLAY) && (dur_ctr == DUR_W'(1));
    assign gap_end  = tick && (state == S_GAP)  && (gap_ctr == GAP_W'(1));
    assign advance  = (note_end && (GAP_TICKS == 0)) || gap_end;

    song_sequencer_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (RESET),
        .en   (tick_en),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state        <= S_IDLE;
            idx          <= '0;
            dur_ctr      <= '0;
            gap_ctr      <= '0;
            // Tracking the live selection means leaving reset is never
            // mistaken for a song change.
            shadow       <= bus.song_sel;
            rom_addr_q   <= '0;
            fullnote_q   <= '0;
            note_start_q <= 1'b0;
            song_done_q  <= 1'b0;
        end else begin
            note_start_q <= 1'b0;
            song_done_q  <= 1'b0;

            if (song_change) begin
                shadow     <= bus.song_sel;
                fullnote_q <= '0;
                idx        <= '0;
                state      <= S_FETCH;
            end else if (advance) begin
                fullnote_q <= '0;
                if (at_last) begin
                    idx         <= '0;
                    song_done_q <= 1'b1;
                    state       <= (LOOP != 0) ? S_FETCH : S_DONE;
                end else begin
                    idx   <= idx + IDX_W'(1);
                    state <= S_FETCH;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!bus.pause) begin
                            state <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        rom_addr_q <= base + ADDR_W'(idx);
                        state      <= S_WAIT;
                    end
                    S_WAIT: begin
                        state <= S_LOAD;
                    end
                    S_LOAD: begin
                        if (end_marker) begin
                            fullnote_q  <= '0;
                            song_done_q <= 1'b1;
                            idx         <= '0;
                            state       <= (LOOP != 0) ? S_FETCH : S_DONE;
                        end else begin
                            fullnote_q   <= FULLNOTE_W'(bus.rom_data[NOTE_MSB:NOTE_LSB]);
                            note_start_q <= 1'b1;
                            dur_ctr      <= DUR_W'(bus.rom_data[DUR_MSB:DUR_LSB])
                                          * DUR_W'(UNIT_TICKS);
                            state        <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (note_end) begin
                            fullnote_q <= '0;
                            gap_ctr    <= GAP_W'(GAP_TICKS);
                            state      <= S_GAP;
                        end else if (tick) begin
                            dur_ctr <= dur_ctr - DUR_W'(1);
                        end
                    end
                    S_GAP: begin
                        if (tick) begin
                            gap_ctr <= gap_ctr - GAP_W'(1);
                        end
                    end
                    S_DONE: begin
                        state <= S_DONE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.fullnote   = fullnote_q;
    assign bus.note_start = note_start_q;
    assign bus.song_done  = song_done_q;
    assign bus.playing    = !bus.pause && ((state == S_PLAY) || (state == S_GAP));

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: randomized note ROM, expected output timelines
// derived from note/gap durations, plus pause, song-change and reset scenarios.
module tb_song_sequencer;

    localparam int CLKF       = 256;
    localparam int TICK_HZ    = 64;
    localparam int CYC_TICK   = CLKF / TICK_HZ;
    localparam int UNIT_TICKS = 2;
    localparam int GAP_TICKS  = 1;
    localparam int SONG_LEN   = 4;
    localparam int MAXC       = 400;

    logic clk;
    logic RESET;

    song_sequencer_if #(.ADDR_W(9)) bus ();

    song_sequencer #(
        .CLKF       (CLKF),
        .TICK_HZ    (TICK_HZ),
        .UNIT_TICKS (UNIT_TICKS),
        .GAP_TICKS  (GAP_TICKS),
        .ADDR_W     (9),
        .SONG1_BASE (0),
        .SONG2_BASE (256),
        .SONG_LEN   (SONG_LEN),
        .LOOP       (1)
    ) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    logic [9:0] rom [512];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Note ROM with one cycle of registered read latency.
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int total = 0;
    int bad   = 0;

    logic [10:0] e_fn [MAXC];
    logic        e_ns [MAXC];
    logic        e_sd [MAXC];
    logic        e_pl [MAXC];
    logic [8:0]  e_ad [MAXC];
    int          last_n = 0;

    function automatic logic [22:0] observed();
        return {bus.fullnote, bus.note_start, bus.song_done, bus.rom_addr, bus.playing};
    endfunction

    // Expected outputs, sample c taken after the c-th clock edge counted from
    // the edge on which fetching begins (edge 0).
    task automatic build_timeline(input int base, input logic [8:0] addr0, input int n);
        int f, idx, l, len, a;
        logic [3:0] dur;
        logic [5:0] note;
        for (int c = 0; c < n; c++) begin
            e_fn[c] = '0; e_ns[c] = 1'b0; e_sd[c] = 1'b0; e_pl[c] = 1'b0; e_ad[c] = addr0;
        end
        f = 0;
        idx = 0;
        while (f < n) begin
            for (int c = f + 1; c < n; c++) e_ad[c] = 9'(base + idx);
            l    = f + 3;
            dur  = rom[base + idx][9:6];
            note = rom[base + idx][5:0];
            if (dur == 4'd0) begin
                if (l < n) e_sd[l] = 1'b1;
                idx = 0;
                f = l;
            end else begin
                len = int'(dur) * UNIT_TICKS * CYC_TICK;
                a   = l + len + GAP_TICKS * CYC_TICK;
                if (l < n) e_ns[l] = 1'b1;
                for (int c = l; c < l + len && c < n; c++) e_fn[c] = {5'b0, note};
                for (int c = l; c < a && c < n; c++) e_pl[c] = 1'b1;
                if (idx == SONG_LEN - 1) begin
                    if (a < n) e_sd[a] = 1'b1;
                    idx = 0;
                end else begin
                    idx++;
                end
                f = a;
            end
        end
    endtask

    // Call just after a falling edge; the next rising edge must be edge 0.
    task automatic run_timeline(input string name, input int base,
                                input logic [8:0] addr0, input int n);
        logic [22:0] exp_v, got;
        build_timeline(base, addr0, n);
        last_n = n;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            exp_v = {e_fn[c], e_ns[c], e_sd[c], e_ad[c], e_pl[c]};
            got   = observed();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL %s cyc=%0d got fn=%0d ns=%0b sd=%0b addr=%0d play=%0b want fn=%0d ns=%0b sd=%0b addr=%0d play=%0b",
                         name, c, got[22:12], got[11], got[10], got[9:1], got[0],
                         exp_v[22:12], exp_v[11], exp_v[10], exp_v[9:1], exp_v[0]);
            end
        end
    endtask

    task automatic check_zero(input string name);
        logic [22:0] got;
        got = observed();
        total++;
        if (got !== 23'd0) begin
            bad++;
            $display("FAIL %s got outputs=%h want 0", name, got);
        end
    endtask

    // Returns just after the falling edge that releases reset.
    task automatic do_reset();
        @(negedge clk);
        RESET = 1'b1;
        #1;
        check_zero("reset_async");
        repeat (2) @(negedge clk);
        check_zero("reset_hold");
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        bus.pause = 1'b0;
        bus.song_sel = 1'b0;
        do_reset();
        run_timeline("song1_loop", 0, 9'd0, 200);
    endtask

    task automatic test_idle_pause();
        bus.pause = 1'b1;
        do_reset();
        repeat (5) begin
            @(negedge clk);
            check_zero("idle_paused");
        end
        bus.pause = 1'b0;
        run_timeline("idle_release", 0, 9'd0, 60);
    endtask

    task automatic test_pause();
        int k, p, s, len, ns_cnt;
        logic seen, ended;
        logic [22:0] got;
        k = $urandom_range(1, 12);
        p = $urandom_range(1, 10);
        s = 3 + k;
        len = 0; ns_cnt = 0; seen = 1'b0; ended = 1'b0;
        bus.pause = 1'b0;
        do_reset();
        for (int c = 0; c < 200 && !ended; c++) begin
            @(negedge clk);
            got = observed();
            if (bus.note_start) ns_cnt++;
            if (bus.fullnote != 0) begin
                seen = 1'b1;
                len++;
            end else if (seen) begin
                ended = 1'b1;
            end
            if (c > s && c <= s + p) begin
                total++;
                if (bus.fullnote !== 11'd27 || bus.playing !== 1'b0) begin
                    bad++;
                    $display("FAIL pause_hold cyc=%0d got fn=%0d play=%0b want fn=27 play=0",
                             c, got[22:12], got[0]);
                end
            end
            if (c == s) bus.pause = 1'b1;
            if (c == s + p) bus.pause = 1'b0;
        end
        bus.pause = 1'b0;
        total++;
        if (!ended) begin
            bad++;
            $display("FAIL pause_timeout got note_end=0 want 1");
        end
        total++;
        if (len != 24 + p) begin
            bad++;
            $display("FAIL pause_len got %0d want %0d", len, 24 + p);
        end
        total++;
        if (ns_cnt != 1) begin
            bad++;
            $display("FAIL pause_note_start got %0d want 1", ns_cnt);
        end
    endtask

    task automatic test_song_change();
        int k;
        k = $urandom_range(1, 20);
        bus.song_sel = 1'b0;
        do_reset();
        repeat (4 + k) @(negedge clk);
        bus.song_sel = 1'b1;
        run_timeline("song2_wrap", 256, 9'd0, 300);
    endtask

    task automatic test_async_reset();
        int k;
        logic [10:0] want;
        k = $urandom_range(1, 6);
        do_reset();
        repeat (4 + k) @(negedge clk);
        want = {5'b0, rom[256][5:0]};
        total++;
        if (bus.fullnote !== want) begin
            bad++;
            $display("FAIL pre_reset_note got %0d want %0d", bus.fullnote, want);
        end
        #1 RESET = 1'b1;
        #1 check_zero("reset_mid_note");
        #1 RESET = 1'b0;
        run_timeline("after_reset_song2", 256, 9'd0, 150);
    endtask

    task automatic test_back_to_back();
        logic [8:0] addr0;
        int n;
        for (int i = 0; i < 4; i++) begin
            addr0 = e_ad[last_n - 1];
            n = $urandom_range(5, 80);
            bus.song_sel = ~bus.song_sel;
            run_timeline("switch", bus.song_sel ? 256 : 0, addr0, n);
        end
    endtask

    initial begin
        RESET = 1'b1;
        bus.pause = 1'b0;
        bus.song_sel = 1'b0;
        for (int i = 0; i < 512; i++) rom[i] = '0;
        rom[0] = {4'd3, 6'd27};
        rom[1] = {4'($urandom_range(1, 3)), 6'($urandom_range(1, 63))};
        rom[2] = {4'd0, 6'($urandom_range(0, 63))};
        rom[3] = {4'($urandom_range(1, 3)), 6'($urandom_range(1, 63))};
        for (int i = 256; i < 260; i++)
            rom[i] = {4'($urandom_range(1, 3)), 6'($urandom_range(1, 63))};

        test_reset();
        test_idle_pause();
        test_pause();
        test_song_change();
        test_async_reset();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
